mdu_ctrl: RTL

Multiply/divide unit controller for the E stage of the five-stage MIPS pipeline. It owns the architectural HI/LO registers. It sequences multi-cycle mult/multu/div/divu operations with a busy counter, and applies mthi/mtlo writes. It supplies mfhi/mflo read data and raises the stall request that holds the D stage while an operation is in flight. It also suppresses operation start when the exception/interrupt flush (req) is active, so a cancelled instruction never modifies HI/LO.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_core.sv | 70 +++++++
 rtl/mdu_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU op-code encoding carried on E_mdu_op (4 bits, codes 9..15 unused)
//   - controller state encoding (S_IDLE, S_BUSY)
//   - small decode helpers used by the core and the controller
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// mdu_core: combinational 64-bit result generator for the MDU.
// Ports:
//   op      in  4   operation code (mdu_pkg encoding)
//   a       in  32  rs operand (multiplicand / dividend)
//   b       in  32  rt operand (multiplier / divisor)
//   hi      out 32  upper half of product, or remainder
//   lo      out 32  lower half of product, or quotient
//   divzero out 1   divide op with b == 0; result must not be committed
// Build option: MDU_DIV_EN -- when undefined, no divider is built and
// DIV/DIVU produce zero with divzero low (the controller never starts them).
module mdu_core
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divzero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               b_zero;

  assign a_s    = a;
  assign b_s    = b;
  assign b_zero = (b == 32'd0);
  // Signed / and % truncate toward zero; the remainder takes the dividend's sign.
  assign quo_s  = b_zero ? 32'sd0 : (a_s / b_s);
  assign rem_s  = b_zero ? 32'sd0 : (a_s % b_s);
  assign quo_u  = b_zero ? 32'd0  : (a / b);
  assign rem_u  = b_zero ? 32'd0  : (a % b);
`endif

  always_comb begin
    hi      = 32'd0;
    lo      = 32'd0;
    divzero = 1'b0;
    case (op)
      MDU_MULT:  {hi, lo} = prod_s;
      MDU_MULTU: {hi, lo} = prod_u;
`ifdef MDU_DIV_EN
      MDU_DIV: begin
        hi      = rem_s;
        lo      = quo_s;
        divzero = b_zero;
      end
      MDU_DIVU: begin
        hi      = rem_u;
        lo      = quo_u;
        divzero = b_zero;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller, owner of architectural HI/LO.
// Ports:
//   clk          in  1   clock, all state on posedge
//   res          in  1   synchronous active-high reset
//   req          in  1   exception/interrupt flush, cancels the E-stage op
//   E_mdu_op     in  4   E-stage op code (mdu_pkg encoding)
//   E_A, E_B     in  32  rs / rt operands
//   D_is_md      in  1   D-stage instruction is an MDU op
//   E_mdu_out    out 32  mfhi -> HI, mflo -> LO, else 0
//   E_busy       out 1   multi-cycle operation in flight
//   D_mdu_stall  out 1   hold D while an op is starting or in flight
//   HI, LO       out 32  architectural HI/LO
// Parameters: MULT_CYCLES, DIV_CYCLES -- busy length of mult/div (>= 1).
// Build option: MDU_DIV_EN -- enables DIV/DIVU; otherwise they act as NONE.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input  logic        clk,
  input  logic        res,
  input  logic        req,
  input  logic [3:0]  E_mdu_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic [31:0] E_mdu_out,
  output logic        E_busy,
  output logic        D_mdu_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pending_hi;
  logic [31:0]      pending_lo;
  logic             pending_skip;

  logic [31:0]      core_hi;
  logic [31:0]      core_lo;
  logic             core_divzero;

  logic             div_op;
  logic             long_op;
  logic             start;
  logic             last_busy;
  logic             mt_ok;

  mdu_core u_core (
    .op      (E_mdu_op),
    .a       (E_A),
    .b       (E_B),
    .hi      (core_hi),
    .lo      (core_lo),
    .divzero (core_divzero)
  );

`ifdef MDU_DIV_EN
  assign div_op = is_div_op(E_mdu_op);
`else
  assign div_op = 1'b0;
`endif

  assign long_op     = is_mult_op(E_mdu_op) | div_op;
  assign E_busy      = (state == S_BUSY);
  // An op already in flight is never interrupted by req; only new starts are.
  assign start       = long_op & ~req & ~E_busy & ~res;
  assign last_busy   = E_busy & (cnt == CNT_ONE);
  assign mt_ok       = ~req & ~E_busy;
  assign D_mdu_stall = D_is_md & (E_busy | start);

  always_comb begin
    E_mdu_out = 32'd0;
    case (E_mdu_op)
      MDU_MFHI: E_mdu_out = HI;
      MDU_MFLO: E_mdu_out = LO;
      default:  ;
    endcase
  end

  // Stage boundary: E-stage start -> busy sequencing (FSM + counter)
  always_ff @(posedge clk) begin
    if (res) begin
      state        <= S_IDLE;
      cnt          <= '0;
      pending_skip <= 1'b0;
    end else if (start) begin
      state        <= S_BUSY;
      cnt          <= div_op ? DIV_LOAD : MULT_LOAD;
      pending_skip <= core_divzero;
    end else if (E_busy) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        state <= S_IDLE;
      end
    end
  end

  // Result is captured at start so the operands may change while busy.
  always_ff @(posedge clk) begin
    if (start) begin
      pending_hi <= core_hi;
      pending_lo <= core_lo;
    end
  end

  // Stage boundary: commit / mt write -> architectural HI/LO
  always_ff @(posedge clk) begin
    if (res) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (last_busy) begin
      if (!pending_skip) begin
        HI <= pending_hi;
        LO <= pending_lo;
      end
    end else if (mt_ok && (E_mdu_op == MDU_MTHI)) begin
      HI <= E_A;
    end else if (mt_ok && (E_mdu_op == MDU_MTLO)) begin
      LO <= E_A;
    end
  end

endmodule
